led_flash_sched: RTL and testbench
==================================

LED_FLASH_SCHED -- requirements
Module: led_flash_sched

Interface
REQ-001 Parameter HALF_PERIOD, default 16000000, clock cycles per LED on-phase and per off-phase; legal range 1 to 2^25-1.
REQ-002 Parameter GAP_PERIOD, default 32000000, clock cycles of dark gap ending each sequence; legal range 1 to 2^25-1.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 req  input  4  level requests; bit i asks for requester i's flash code.
REQ-006 grant  output  4  one-hot owner of the LED for the current sequence; all-zero when idle.
REQ-007 busy  output  1  high while a sequence is in progress (state not IDLE).
REQ-008 done  output  1  one-cycle pulse marking sequence completion.
REQ-009 led_out  output  1  drive to the shared LED.

Function
REQ-010 The block SHALL share one LED among 4 requesters; requester i's flash code SHALL be exactly i+1 blinks followed by one gap.
REQ-011 The FSM SHALL have states IDLE, ON, OFF and GAP; all outputs SHALL be registered.
REQ-012 Arbitration SHALL be round-robin: search starts at index (last_grant+1) mod 4 and picks the first set req bit.
REQ-013 IDLE with req!=0 at an edge -> next cycle: state ON, grant=onehot(sel), blink counter=sel+1, timer=0, led_out=1, busy=1.
REQ-014 IDLE with req==0 -> stay IDLE, led_out=0, grant=0, busy=0.
REQ-015 ON SHALL last exactly HALF_PERIOD cycles with led_out=1, then go to OFF with timer=0.
REQ-016 OFF SHALL last exactly HALF_PERIOD cycles with led_out=0. At its end the blink counter decrements; remaining>0 -> ON, else -> GAP.
REQ-017 GAP SHALL last exactly GAP_PERIOD cycles with led_out=0, then go to IDLE.
REQ-018 On GAP exit, last_grant SHALL load sel. The first IDLE cycle SHALL have done=1, grant=0, busy=0.
REQ-019 The IDLE cycle carrying done SHALL also arbitrate, so back-to-back sequences have exactly one IDLE cycle between them.
REQ-020 Total sequence length for requester i SHALL be (i+1)*2*HALF_PERIOD + GAP_PERIOD cycles (grant high for this many cycles).
REQ-021 Once a sequence starts, req is ignored until it completes.
REQ-022 Dropping req mid-sequence SHALL NOT abort or shorten the sequence.
REQ-023 A requester holding req continuously SHALL be re-granted only after every other asserted requester has been served once.
REQ-024 The timer SHALL be 25 bits and compare against PERIOD-1. With HALF_PERIOD=1, ON and OFF SHALL each last one cycle.
REQ-025 grant SHALL never have more than one bit set; grant!=0 if and only if busy=1.

Reset
REQ-026 rst high at an edge -> next cycle: state IDLE, timer=0, blink counter=0, grant=0, busy=0, done=0, led_out=0.
REQ-027 On reset, last_grant SHALL be 3, so requester 0 has first priority.
REQ-028 rst SHALL take priority over all other inputs, including mid-sequence; the aborted sequence SHALL produce no done pulse.
REQ-029 Arbitration SHALL resume on the first edge with rst low.

Verification (HALF_PERIOD=4, GAP_PERIOD=8)
REQ-030 Single request: after reset, req=0001 held one cycle.
  -> grant=0001 for 16 cycles; led_out 1 for 4 cycles, then 0 for 12; done one cycle after grant falls.
REQ-031 Longest code: req=1000.
  -> 4 blinks (4 high / 4 low each), then 8-cycle gap; grant high 40 cycles; 4 rising edges on led_out.
REQ-032 Round robin: req=1111 held.
  -> grant order 0001, 0010, 0100, 1000, 0001; each pair of sequences separated by one IDLE cycle with done=1.
REQ-033 Fairness with persistent requester: req=0011 held, last_grant=0.
  -> grant 0010 then 0001, alternating; neither served twice in a row.
REQ-034 Reset mid-sequence: rst pulsed during the second blink of requester 2.
  -> next cycle all outputs 0, no done.
  -> with req=0100 still held, a new 3-blink sequence starts with grant=0100.
REQ-035 Request drop: req=0100 asserted one cycle, then 0.
  -> full 32-cycle sequence completes with 3 blinks and done pulse.
  -> block then stays IDLE.

Source files
------------

// File: rtl/led_flash_sched.sv
// Shared-LED flash-code scheduler: four requesters take turns on one LED.
// Requester i is shown as i+1 blinks followed by a dark gap.
module led_flash_sched #(
  parameter int unsigned HALF_PERIOD = 16000000,
  parameter int unsigned GAP_PERIOD  = 32000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] grant,
  output logic       busy,
  output logic       done,
  output logic       led_out
);

  localparam int unsigned TW   = 25;
  localparam int unsigned NREQ = 4;
  localparam int unsigned IW   = 2;
  localparam int unsigned BW   = 3;

  localparam logic [TW-1:0] HALF_LAST = TW'(HALF_PERIOD - 1);
  localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_PERIOD - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ON,
    S_OFF,
    S_GAP
  } state_t;

  state_t          state, state_n;
  logic [TW-1:0]   timer, timer_n;
  logic [BW-1:0]   blinks, blinks_n;
  logic [IW-1:0]   sel, sel_n;
  logic [IW-1:0]   last_grant, last_grant_n;
  logic [3:0]      grant_n;
  logic            busy_n;
  logic            done_n;
  logic            led_n;

  logic            arb_valid;
  logic [IW-1:0]   arb_sel;
  logic [IW-1:0]   arb_idx;

  // Round-robin pick: first set request after the previous owner, wrapping.
  always_comb begin
    arb_valid = 1'b0;
    arb_sel   = last_grant;
    arb_idx   = last_grant;
    for (int k = 1; k <= NREQ; k++) begin
      arb_idx = last_grant + IW'(k);
      if (!arb_valid && req[arb_idx]) begin
        arb_valid = 1'b1;
        arb_sel   = arb_idx;
      end
    end
  end

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_n      = state;
    timer_n      = timer + TW'(1);
    blinks_n     = blinks;
    sel_n        = sel;
    last_grant_n = last_grant;
    grant_n      = grant;
    busy_n       = busy;
    done_n       = 1'b0;
    led_n        = led_out;

    case (state)
      S_IDLE: begin
        timer_n = '0;
        if (arb_valid) begin
          state_n  = S_ON;
          sel_n    = arb_sel;
          blinks_n = BW'(arb_sel) + BW'(1);
          grant_n  = 4'b0001 << arb_sel;
          busy_n   = 1'b1;
          led_n    = 1'b1;
        end else begin
          grant_n = '0;
          busy_n  = 1'b0;
          led_n   = 1'b0;
        end
      end
      S_ON: begin
        if (timer == HALF_LAST) begin
          state_n = S_OFF;
          timer_n = '0;
          led_n   = 1'b0;
        end
      end
      S_OFF: begin
        if (timer == HALF_LAST) begin
          timer_n  = '0;
          blinks_n = blinks - BW'(1);
          if (blinks != BW'(1)) begin
            state_n = S_ON;
            led_n   = 1'b1;
          end else begin
            state_n = S_GAP;
          end
        end
      end
      S_GAP: begin
        if (timer == GAP_LAST) begin
          state_n      = S_IDLE;
          timer_n      = '0;
          last_grant_n = sel;
          grant_n      = '0;
          busy_n       = 1'b0;
          done_n       = 1'b1;
          led_n        = 1'b0;
        end
      end
      default: begin
        state_n = S_IDLE;
        timer_n = '0;
      end
    endcase
  end

  // Reset leaves requester 0 with first priority (last owner = 3).
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      timer      <= '0;
      blinks     <= '0;
      sel        <= '0;
      last_grant <= IW'(NREQ - 1);
      grant      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      led_out    <= 1'b0;
    end else begin
      state      <= state_n;
      timer      <= timer_n;
      blinks     <= blinks_n;
      sel        <= sel_n;
      last_grant <= last_grant_n;
      grant      <= grant_n;
      busy       <= busy_n;
      done       <= done_n;
      led_out    <= led_n;
    end
  end

endmodule

// File: tb/tb_led_flash_sched.sv
// Bench for led_flash_sched: two instances (HALF=4/GAP=8 and HALF=1/GAP=2) against a
// sequence-level reference model, plus directed checks of the key scenarios.
module tb_led_flash_sched;

  localparam int unsigned HP0 = 4;
  localparam int unsigned GP0 = 8;
  localparam int unsigned HP1 = 1;
  localparam int unsigned GP1 = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;

  logic [3:0] grant0, grant1;
  logic       busy0, busy1, done0, done1, led0, led1;

  int checks   = 0;
  int failures = 0;

  led_flash_sched #(.HALF_PERIOD(HP0), .GAP_PERIOD(GP0)) dut0 (
    .clk(clk), .rst(rst), .req(req),
    .grant(grant0), .busy(busy0), .done(done0), .led_out(led0)
  );

  led_flash_sched #(.HALF_PERIOD(HP1), .GAP_PERIOD(GP1)) dut1 (
    .clk(clk), .rst(rst), .req(req),
    .grant(grant1), .busy(busy1), .done(done1), .led_out(led1)
  );

  always #5 clk = ~clk;

  // Sequence-level model: an active sequence is (owner, elapsed cycles t).
  bit          m_act[2]   = '{0, 0};
  int unsigned m_t[2]     = '{0, 0};
  int unsigned m_own[2]   = '{0, 0};
  int unsigned m_last[2]  = '{3, 3};
  bit          m_done[2]  = '{0, 0};
  bit          m_start[2] = '{0, 0};

  function automatic int unsigned hp_of(input int k);
    return (k == 0) ? HP0 : HP1;
  endfunction

  function automatic int unsigned gp_of(input int k);
    return (k == 0) ? GP0 : GP1;
  endfunction

  function automatic int unsigned seq_len(input int k, input int unsigned o);
    return (o + 1) * 2 * hp_of(k) + gp_of(k);
  endfunction

  task automatic model_tick(input logic [3:0] r, input logic rs);
    for (int k = 0; k < 2; k++) begin
      m_start[k] = 1'b0;
      if (rs) begin
        m_act[k] = 1'b0; m_t[k] = 0; m_done[k] = 1'b0; m_last[k] = 3;
      end else if (m_act[k]) begin
        m_t[k] = m_t[k] + 1;
        m_done[k] = 1'b0;
        if (m_t[k] == seq_len(k, m_own[k])) begin
          m_act[k] = 1'b0; m_done[k] = 1'b1; m_last[k] = m_own[k];
        end
      end else begin
        m_done[k] = 1'b0;
        for (int j = 1; j <= 4; j++) begin
          int unsigned idx;
          idx = (m_last[k] + j) % 4;
          if (!m_act[k] && r[idx]) begin
            m_act[k] = 1'b1; m_own[k] = idx; m_t[k] = 0; m_start[k] = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    for (int k = 0; k < 2; k++) begin
      logic [3:0]  eg;
      logic        el;
      int unsigned h;
      h  = hp_of(k);
      eg = m_act[k] ? (4'b0001 << m_own[k]) : 4'b0000;
      el = m_act[k] && (m_t[k] < 2 * h * (m_own[k] + 1)) && ((m_t[k] % (2 * h)) < h);
      chk(k == 0 ? "grant0" : "grant1", 32'(k == 0 ? grant0 : grant1), 32'(eg));
      chk(k == 0 ? "busy0"  : "busy1",  32'(k == 0 ? busy0  : busy1),  32'(m_act[k]));
      chk(k == 0 ? "done0"  : "done1",  32'(k == 0 ? done0  : done1),  32'(m_done[k]));
      chk(k == 0 ? "led0"   : "led1",   32'(k == 0 ? led0   : led1),   32'(el));
    end
  endtask

  // One clock: drive inputs, let the edge happen, advance model, compare 1ns later.
  task automatic step(input logic [3:0] r, input logic rs);
    req = r;
    rst = rs;
    @(posedge clk);
    model_tick(r, rs);
    #1;
    check_model();
  endtask

  task automatic do_reset();
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b1);
  endtask

  // Step with req held until instance 0 starts a new sequence; bounded.
  task automatic run_to_start(input logic [3:0] r, output bit found);
    found = 1'b0;
    for (int n = 0; n < 200 && !found; n++) begin
      step(r, 1'b0);
      if (m_start[0]) found = 1'b1;
    end
  endtask

  initial begin
    bit          found;
    int          cnt;
    int          rises;
    logic        prev;
    logic [3:0]  rr_exp [5];
    logic [3:0]  fair_exp [4];
    logic [3:0]  rq;

    #2;
    do_reset();
    chk("reset_grant", 32'(grant0), 32'h0);
    chk("reset_led", 32'(led0), 32'h0);

    // Single request from requester 0, held one cycle.
    step(4'b0001, 1'b0);
    cnt = 1; rises = 1; prev = led0;
    chk("single_grant", 32'(grant0), 32'h1);
    for (int n = 0; n < 30; n++) begin
      step(4'b0000, 1'b0);
      if (grant0 == 4'b0001) cnt++;
      if (led0 && !prev) rises++;
      prev = led0;
    end
    chk("single_len", 32'(cnt), 32'd16);
    chk("single_rises", 32'(rises), 32'd1);

    // Longest code, requester 3.
    do_reset();
    step(4'b1000, 1'b0);
    cnt = 1; rises = 1; prev = led0;
    for (int n = 0; n < 50; n++) begin
      step(4'b1000, 1'b0);
      if (grant0 == 4'b1000 && m_own[0] == 3 && m_act[0]) cnt++;
      if (led0 && !prev && m_own[0] == 3) rises++;
      prev = led0;
      if (m_done[0]) break;
    end
    chk("long_len", 32'(cnt), 32'd40);
    chk("long_rises", 32'(rises), 32'd4);
    chk("long_done", 32'(done0), 32'h1);

    // Round robin with all requesters held.
    rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      run_to_start(4'b1111, found);
      chk("rr_found", 32'(found), 32'h1);
      chk("rr_order", 32'(grant0), 32'(rr_exp[i]));
    end

    // Fairness: requester 0 served first, then 0 and 1 held together.
    fair_exp = '{4'b0010, 4'b0001, 4'b0010, 4'b0001};
    do_reset();
    step(4'b0001, 1'b0);
    for (int n = 0; n < 20; n++) step(4'b0000, 1'b0);
    for (int i = 0; i < 4; i++) begin
      run_to_start(4'b0011, found);
      chk("fair_found", 32'(found), 32'h1);
      chk("fair_order", 32'(grant0), 32'(fair_exp[i]));
    end

    // Reset during the second blink of requester 2.
    do_reset();
    step(4'b0100, 1'b0);
    for (int n = 0; n < 20 && m_t[0] != 9; n++) step(4'b0100, 1'b0);
    chk("midrst_at_blink2", 32'(m_t[0]), 32'd9);
    step(4'b0100, 1'b1);
    chk("midrst_grant", 32'(grant0), 32'h0);
    chk("midrst_done", 32'(done0), 32'h0);
    chk("midrst_busy", 32'(busy0), 32'h0);
    step(4'b0100, 1'b0);
    chk("midrst_restart", 32'(grant0), 32'h4);

    // Request dropped after one cycle: full sequence, one done, then idle.
    do_reset();
    step(4'b0100, 1'b0);
    cnt = 1; rises = 1; prev = led0;
    for (int n = 0; n < 45; n++) begin
      step(4'b0000, 1'b0);
      if (grant0 == 4'b0100) cnt++;
      if (led0 && !prev) rises++;
      if (done0) found = 1'b1;
      prev = led0;
    end
    chk("drop_len", 32'(cnt), 32'd32);
    chk("drop_rises", 32'(rises), 32'd3);
    chk("drop_idle", 32'(busy0), 32'h0);

    // Random requests with occasional reset.
    rq = 4'b0000;
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 7) == 0) rq = 4'($urandom);
      step(rq, $urandom_range(0, 299) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
